// File: rtl/pipeline_control_unit_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// default timing parameters and the per-stage control bundle.
package pipeline_control_unit_pkg;

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StMemWait = 3'd1,
        StDrain   = 3'd2,
        StHalted  = 3'd3,
        StError   = 3'd4
    } pcu_state_e;

    localparam int unsigned MemTimeoutDefault  = 15;
    localparam int unsigned DrainCyclesDefault = 3;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } pcu_ctrl_t;

    localparam pcu_ctrl_t CtrlOff    = pcu_ctrl_t'(7'b0000000);
    localparam pcu_ctrl_t CtrlRun    = pcu_ctrl_t'(7'b1111000);
    localparam pcu_ctrl_t CtrlFrozen = pcu_ctrl_t'(7'b0000001);
    localparam pcu_ctrl_t CtrlDrain  = pcu_ctrl_t'(7'b0111110);
    localparam pcu_ctrl_t CtrlBranch = pcu_ctrl_t'(7'b1111110);
    localparam pcu_ctrl_t CtrlBubble = pcu_ctrl_t'(7'b0011010);

    // Branch squashes the stalled instruction, so it outranks the load-use bubble.
    function automatic pcu_ctrl_t run_decode(input logic branch_taken,
                                             input logic hazard_stall);
        pcu_ctrl_t ctrl;
        if (branch_taken) begin
            ctrl = CtrlBranch;
        end else if (hazard_stall) begin
            ctrl = CtrlBubble;
        end else begin
            ctrl = CtrlRun;
        end
        return ctrl;
    endfunction

    function automatic logic counts_stall(input pcu_state_e state);
        return (state == StRun) || (state == StMemWait) || (state == StDrain);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: decodes per-stage enables from
// the FSM state and live requests, and tracks memory timeout, HALT drain and stall cycles.
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = MemTimeoutDefault,
    parameter int unsigned DRAIN_CYCLES = DrainCyclesDefault,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_hazard_stall,
    input  logic                 i_branch_taken,
    input  logic                 i_mem_req,
    input  logic                 i_mem_ready,
    input  logic                 i_halt_req,
    input  logic                 i_resume,
    output logic                 o_pc_enable,
    output logic                 o_if_id_enable,
    output logic                 o_id_ex_enable,
    output logic                 o_ex_mem_enable,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_flush,
    output logic                 o_mem_wb_bubble,
    output logic [2:0]           o_state_out,
    output logic [CNT_WIDTH-1:0] o_stall_count,
    output logic                 o_timeout_error
);

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);
    localparam logic [2:0] DrainInit  = 3'(DRAIN_CYCLES - 1);

    pcu_state_e r_state;
    logic [7:0] r_wait_cnt;
    logic [2:0] r_drain_cnt;
    logic       r_timeout_error;

    pcu_state_e w_state_d;
    logic [7:0] w_wait_d;
    logic [2:0] w_drain_d;
    logic       w_timeout_d;
    pcu_ctrl_t  w_ctrl;
    pcu_ctrl_t  w_ctrl_out;
    logic       w_mem_wait;
    logic       w_stall_inc;

    assign w_mem_wait = i_mem_req && !i_mem_ready;

    always_comb begin
        w_ctrl      = CtrlOff;
        w_state_d   = r_state;
        w_wait_d    = r_wait_cnt;
        w_drain_d   = r_drain_cnt;
        w_timeout_d = r_timeout_error;
        case (r_state)
            StRun: begin
                if (w_mem_wait) begin
                    w_ctrl    = CtrlFrozen;
                    w_state_d = StMemWait;
                    w_wait_d  = 8'd1;
                end else if (i_halt_req) begin
                    w_ctrl    = CtrlDrain;
                    w_state_d = StDrain;
                    w_drain_d = DrainInit;
                end else begin
                    w_ctrl = run_decode(i_branch_taken, i_hazard_stall);
                end
            end
            StMemWait: begin
                if (i_mem_ready) begin
                    w_ctrl    = run_decode(i_branch_taken, i_hazard_stall);
                    w_state_d = StRun;
                    w_wait_d  = 8'd0;
                end else if (r_wait_cnt == TimeoutCnt) begin
                    w_ctrl      = CtrlFrozen;
                    w_state_d   = StError;
                    w_timeout_d = 1'b1;
                end else begin
                    w_ctrl   = CtrlFrozen;
                    w_wait_d = r_wait_cnt + 8'd1;
                end
            end
            StDrain: begin
                // A memory wait freezes the back end too, so the drain count must hold.
                if (w_mem_wait) begin
                    w_ctrl = CtrlFrozen;
                end else begin
                    w_ctrl = CtrlDrain;
                    if (r_drain_cnt == 3'd0) begin
                        w_state_d = StHalted;
                    end else begin
                        w_drain_d = r_drain_cnt - 3'd1;
                    end
                end
            end
            StHalted: begin
                if (i_resume) begin
                    w_state_d = StRun;
                end
            end
            StError: begin
                w_state_d = StError;
            end
            default: begin
                w_state_d = StError;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= StRun;
            r_wait_cnt      <= 8'd0;
            r_drain_cnt     <= 3'd0;
            r_timeout_error <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_wait_cnt      <= w_wait_d;
            r_drain_cnt     <= w_drain_d;
            r_timeout_error <= w_timeout_d;
        end
    end

    assign w_stall_inc = !w_ctrl.pc_en && counts_stall(r_state);

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_counter (
        .i_clock (i_clock),
        .i_clear (i_reset),
        .i_inc   (w_stall_inc),
        .o_count (o_stall_count)
    );

    // Outputs are forced quiet for the whole time reset is held.
    assign w_ctrl_out      = i_reset ? CtrlOff : w_ctrl;
    assign o_pc_enable     = w_ctrl_out.pc_en;
    assign o_if_id_enable  = w_ctrl_out.if_id_en;
    assign o_id_ex_enable  = w_ctrl_out.id_ex_en;
    assign o_ex_mem_enable = w_ctrl_out.ex_mem_en;
    assign o_if_id_flush   = w_ctrl_out.if_id_flush;
    assign o_id_ex_flush   = w_ctrl_out.id_ex_flush;
    assign o_mem_wb_bubble = w_ctrl_out.mem_wb_bubble;
    assign o_state_out     = r_state;
    assign o_timeout_error = r_timeout_error;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed plus randomized bench for pipeline_control_unit against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipeline_control_unit;

    localparam int MEM_TIMEOUT  = 15;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_WIDTH    = 5;
    localparam int CNT_MAX      = (1 << CNT_WIDTH) - 1;

    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_DRN  = 2;
    localparam int M_HALT = 3;
    localparam int M_ERR  = 4;

    // {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, mem_wb_bubble}
    localparam logic [6:0] E_FLOW   = 7'b1111000;
    localparam logic [6:0] E_FREEZE = 7'b0000001;
    localparam logic [6:0] E_DRAIN  = 7'b0111110;
    localparam logic [6:0] E_BRANCH = 7'b1111110;
    localparam logic [6:0] E_LOADUS = 7'b0011010;
    localparam logic [6:0] E_QUIET  = 7'b0000000;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 hz = 1'b0, br = 1'b0, mr = 1'b0, rdy = 1'b0, halt = 1'b0, res = 1'b0;
    logic                 pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, bubble;
    logic [2:0]           state_out;
    logic [CNT_WIDTH-1:0] stall_count;
    logic                 timeout_error;
    logic [6:0]           ctrl_obs;

    int n_asserts = 0;
    int n_fail    = 0;

    int m_state = 0, m_wait = 0, m_drain = 0, m_stall = 0;
    bit m_terr = 1'b0;

    always #5 clock = ~clock;

    assign ctrl_obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, bubble};

    pipeline_control_unit #(
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_hazard_stall  (hz),
        .i_branch_taken  (br),
        .i_mem_req       (mr),
        .i_mem_ready     (rdy),
        .i_halt_req      (halt),
        .i_resume        (res),
        .o_pc_enable     (pc_en),
        .o_if_id_enable  (ifid_en),
        .o_id_ex_enable  (idex_en),
        .o_ex_mem_enable (exmem_en),
        .o_if_id_flush   (ifid_fl),
        .o_id_ex_flush   (idex_fl),
        .o_mem_wb_bubble (bubble),
        .o_state_out     (state_out),
        .o_stall_count   (stall_count),
        .o_timeout_error (timeout_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] flow_decode();
        if (br) return E_BRANCH;
        if (hz) return E_LOADUS;
        return E_FLOW;
    endfunction

    function automatic logic [6:0] expect_ctrl();
        bit waiting = mr && !rdy;
        case (m_state)
            M_RUN:   return waiting ? E_FREEZE : (halt ? E_DRAIN : flow_decode());
            M_WAIT:  return rdy ? flow_decode() : E_FREEZE;
            M_DRN:   return waiting ? E_FREEZE : E_DRAIN;
            default: return E_QUIET;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_RUN;
        m_wait  = 0;
        m_drain = 0;
        m_stall = 0;
        m_terr  = 1'b0;
    endtask

    task automatic model_tick(input bit pc_on);
        bit waiting = mr && !rdy;
        if (!pc_on && m_state <= M_DRN && m_stall < CNT_MAX) m_stall++;
        if (m_state == M_RUN) begin
            if (waiting) begin
                m_state = M_WAIT;
                m_wait  = 1;
            end else if (halt) begin
                m_state = M_DRN;
                m_drain = DRAIN_CYCLES - 1;
            end
        end else if (m_state == M_WAIT) begin
            if (rdy) begin
                m_state = M_RUN;
                m_wait  = 0;
            end else if (m_wait == MEM_TIMEOUT) begin
                m_state = M_ERR;
                m_terr  = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (m_state == M_DRN) begin
            if (!waiting) begin
                if (m_drain == 0) m_state = M_HALT;
                else m_drain--;
            end
        end else if (m_state == M_HALT) begin
            if (res) m_state = M_RUN;
        end
    endtask

    // Called at posedge+1; inputs settle, outputs compared at the falling edge.
    task automatic step(input string tag, input bit h, input bit b, input bit m,
                        input bit r, input bit ha, input bit rs);
        logic [6:0] exp;
        hz = h; br = b; mr = m; rdy = r; halt = ha; res = rs;
        #4;
        exp = expect_ctrl();
        check({tag, ".ctrl"}, 32'(ctrl_obs), 32'(exp));
        check({tag, ".state"}, 32'(state_out), 32'(m_state));
        check({tag, ".stall"}, 32'(stall_count), 32'(m_stall));
        check({tag, ".terr"}, 32'(timeout_error), 32'(m_terr));
        @(posedge clock);
        #1;
        model_tick(exp[6]);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check({tag, ".ctrl"}, 32'(ctrl_obs), 32'(E_QUIET));
        check({tag, ".state"}, 32'(state_out), 32'(M_RUN));
        check({tag, ".stall"}, 32'(stall_count), 32'd0);
        check({tag, ".terr"}, 32'(timeout_error), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1;
        do_reset("por");
        step("idle", 0, 0, 0, 0, 0, 0);

        step("loaduse", 1, 0, 0, 0, 0, 0);
        check("loaduse_count", 32'(stall_count), 32'd1);
        step("after_lu", 0, 0, 0, 0, 0, 0);

        step("br_hz", 1, 1, 0, 0, 0, 0);
        check("br_hz_count", 32'(stall_count), 32'd1);

        for (int i = 0; i < 4; i++) step("memwait", 0, 0, 1, 0, 0, 0);
        step("memrel", 0, 0, 1, 1, 0, 0);
        check("memrel_state", 32'(state_out), 32'd0);
        check("memrel_count", 32'(stall_count), 32'd5);

        step("halt", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < DRAIN_CYCLES; i++) step("drain", 0, 0, 0, 0, 0, 0);
        check("halted_state", 32'(state_out), 32'd3);
        check("halted_count", 32'(stall_count), 32'd9);
        step("halted", 0, 0, 0, 0, 1, 0);
        step("resume", 0, 0, 0, 0, 0, 1);
        check("resumed_state", 32'(state_out), 32'd0);

        for (int i = 0; i < MEM_TIMEOUT + 1; i++) step("tmo_wait", 0, 0, 1, 0, 0, 0);
        check("tmo_state", 32'(state_out), 32'd4);
        check("tmo_flag", 32'(timeout_error), 32'd1);
        step("err_resume", 0, 0, 0, 0, 0, 1);
        step("err_ready", 0, 0, 1, 1, 0, 0);
        check("err_sticky", 32'(state_out), 32'd4);

        do_reset("rst_clean");
        for (int i = 0; i < 5; i++) step("pre_rst_wait", 0, 0, 1, 0, 0, 0);
        do_reset("rst_midwait");
        step("post_rst", 0, 0, 0, 0, 0, 0);

        step("halt2", 0, 0, 0, 0, 1, 0);
        step("drain_wait", 0, 0, 1, 0, 0, 0);
        step("drain_wait", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < DRAIN_CYCLES; i++) step("drain2", 0, 0, 0, 0, 0, 0);
        check("halted2_state", 32'(state_out), 32'd3);
        step("resume2", 0, 0, 0, 0, 0, 1);

        do_reset("rst_sat");
        for (int i = 0; i < CNT_MAX + 8; i++) step("sat", 1, 0, 0, 0, 0, 0);
        check("sat_count", 32'(stall_count), 32'(CNT_MAX));

        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) do_reset("rnd_rst");
            step("rnd",
                 ($urandom % 4) == 0,
                 ($urandom % 6) == 0,
                 ($urandom % 3) == 0,
                 ($urandom % 2) == 0,
                 ($urandom % 25) == 0,
                 ($urandom % 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). It combines three inputs into per-stage register enables, flushes and bubble control:
- the load-use stall request from the hazard detection unit;
- the taken-branch indication from EX;
- the data-memory handshake.
It also owns a multi-cycle memory-wait FSM with timeout, a HALT drain/resume sequence, and a saturating stall-cycle counter used for performance monitoring.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before the ERROR state (range 2..255)
DRAIN_CYCLES, 3, cycles the back end keeps running after HALT to empty EX/MEM/WB (range 1..7)
CNT_WIDTH, 16, width of stall_count

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high
hazard_stall  in  1  load-use hazard from HDU (its muxSelector)
branch_taken  in  1  taken branch/jump resolved in EX this cycle
mem_req  in  1  MEM stage holds a load/store this cycle
mem_ready  in  1  data memory completes the access this cycle
halt_req  in  1  HALT instruction in EX
resume  in  1  external restart pulse
pc_enable  out  1  PC write enable
if_id_enable  out  1  IF/ID register enable
id_ex_enable  out  1  ID/EX register enable
ex_mem_enable  out  1  EX/MEM register enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  load NOP into ID/EX (bubble)
mem_wb_bubble  out  1  load NOP into MEM/WB
state_out  out  3  current FSM state
stall_count  out  CNT_WIDTH  saturating count of front-end stall cycles
timeout_error  out  1  sticky memory-timeout flag

Behaviour:
- Structure: state, wait_cnt (8 bit), drain_cnt (3 bit), stall_count and timeout_error are registered. Control outputs are a combinational decode of state plus the current inputs, so a single-cycle load-use stall costs no extra latency.
- Reset (asynchronous, active-high): state=RUN, all counters=0, timeout_error=0. While reset is high, every enable, flush and bubble output is 0.
- Default (RUN, no event): all enables=1, flushes=0, bubble=0.
- States: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, ERROR=4.
- RUN priority, highest first: memory wait > halt_req > branch_taken > hazard_stall.
  - mem_req && !mem_ready:
    - pc/if_id/id_ex/ex_mem enables=0, mem_wb_bubble=1.
    - Next state MEM_WAIT, wait_cnt=1.
    - All other requests are ignored this cycle; they are re-sampled later because the stages hold.
  - halt_req:
    - pc_enable=0, if_id_flush=1, id_ex_flush=1.
    - Next state DRAIN, drain_cnt=DRAIN_CYCLES-1.
  - branch_taken:
    - if_id_flush=1, id_ex_flush=1, all enables=1.
    - hazard_stall is ignored because the stalled instruction is squashed.
  - hazard_stall alone: pc_enable=0, if_id_enable=0, id_ex_flush=1. Exactly one bubble per asserted cycle.
- MEM_WAIT:
  - Frozen as in the RUN memory-wait case.
  - mem_ready=1: release in the same cycle (RUN outputs, with branch/stall decode applied) and go to RUN, wait_cnt=0.
  - Otherwise wait_cnt++. When wait_cnt==MEM_TIMEOUT with no ready: go to ERROR and set timeout_error=1.
- DRAIN:
  - pc_enable=0, if_id_flush=1, id_ex_flush=1; ex_mem_enable=1, mem_wb_bubble=0.
  - drain_cnt decrements each cycle. At 0 go to HALTED.
  - A memory wait during DRAIN freezes as in MEM_WAIT, and drain_cnt holds; no state change.
- HALTED:
  - All enables=0; other inputs are ignored.
  - resume=1: go to RUN next cycle.
- ERROR: all enables=0, sticky until reset; resume is ignored.
- stall_count: +1 on every cycle with pc_enable==0 while state is RUN, MEM_WAIT or DRAIN. It saturates at all-ones and never wraps.
- state_out mirrors the state register.

Decomposition:
- pipeline_ctrl_defs.vh: state encodings and the default values of MEM_TIMEOUT and DRAIN_CYCLES.
- One sub-module, sat_counter: parameterized width, synchronous increment, asynchronous active-high clear, holds at max. Used for stall_count.

Test Plan:
- Reset: assert reset mid-MEM_WAIT (wait_cnt=5) -> state_out=0, all enables=0, stall_count=0 immediately; after deassert, all enables=1.
- Load-use: hazard_stall=1 for one cycle in RUN -> pc_enable=0, if_id_enable=0, id_ex_flush=1 that cycle only; stall_count=1.
- Simultaneous branch_taken=1 and hazard_stall=1 -> if_id_flush=1, id_ex_flush=1, pc_enable=1, stall_count unchanged.
- Memory wait: mem_req=1 with mem_ready low for 4 cycles, then high -> 4 frozen cycles with mem_wb_bubble=1, release on the ready cycle, state back to 0.
- Timeout: mem_req=1, mem_ready=0 forever, MEM_TIMEOUT=15 -> state_out=4 and timeout_error=1 after 15 cycles; resume has no effect.
- Halt: halt_req=1, DRAIN_CYCLES=3 -> 3 cycles with ex_mem_enable=1 and pc_enable=0, then state_out=3; resume=1 -> RUN next cycle.
